// File: rtl/rmt_pkg.sv
// Shared definitions for the ingress segment collector: FSM encoding, header
// field offsets within beat 0, and the header-segment width helper.
package rmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SND   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } seg_state_e;

  // VLAN TCI: byte 14 sits at bits 119:112, byte 15 at bits 127:120
  localparam int VLAN_LO_OFF = 112;
  localparam int VLAN_HI_OFF = 120;

  // TPID: byte 12 at bits 103:96, byte 13 at bits 111:104
  localparam int          TPID_LO_OFF = 96;
  localparam int          TPID_HI_OFF = 104;
  localparam logic [15:0] TPID_VLAN   = 16'h8100;

  // Header segment is two stream beats wide
  function automatic int seg_width(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/parser_wait_segs.sv
// Ingress segment collector: packs the first two beats into a header segment,
// extracts the VLAN ID and forwards every beat. Optional macro PARSER_VLAN_CHECK_EN.
module parser_wait_segs
  import rmt_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_VLANID_WIDTH     = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [2*C_AXIS_DATA_WIDTH-1:0]    segs_tdata,
  output logic [2*C_AXIS_TUSER_WIDTH-1:0]   segs_tuser,
  output logic [C_AXIS_DATA_WIDTH/4-1:0]    segs_tkeep,
  output logic [1:0]                        segs_tlast,
  output logic                              segs_valid,
  input  logic                              segs_ready,
  output logic [C_VLANID_WIDTH-1:0]         vlan,
  output logic                              vlan_valid,
  input  logic                              vlan_ready,
  output logic [C_AXIS_DATA_WIDTH-1:0]      pkt_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     pkt_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    pkt_tkeep,
  output logic                              pkt_tlast,
  output logic                              pkt_valid,
  input  logic                              pkt_ready
);

  localparam int SEG_W  = seg_width(C_AXIS_DATA_WIDTH);
  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

`ifdef PARSER_VLAN_CHECK_EN
  localparam bit VLAN_CHECK = 1'b1;
`else
  localparam bit VLAN_CHECK = 1'b0;
`endif

  seg_state_e state_q, state_d;

  logic accept;
  logic tag_hit, tag_ok;
  logic pkt_vld_d, vlan_vld_d, segs_vld_d;
  logic seg_single, seg_pair, beat0_load;

  logic [C_AXIS_DATA_WIDTH-1:0]  beat0_tdata_p0;
  logic [C_AXIS_TUSER_WIDTH-1:0] beat0_tuser_p0;
  logic [KEEP_W-1:0]             beat0_tkeep_p0;

  assign s_axis_tready = pkt_ready & segs_ready & vlan_ready & ~reset;
  assign accept        = s_axis_tvalid & s_axis_tready;

  assign tag_hit = (s_axis_tdata[TPID_LO_OFF +: 8] == TPID_VLAN[15:8]) &&
                   (s_axis_tdata[TPID_HI_OFF +: 8] == TPID_VLAN[7:0]);
  assign tag_ok  = ~VLAN_CHECK | tag_hit;

  always_comb begin
    state_d    = state_q;
    pkt_vld_d  = 1'b0;
    vlan_vld_d = 1'b0;
    segs_vld_d = 1'b0;
    seg_single = 1'b0;
    seg_pair   = 1'b0;
    beat0_load = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (tag_ok) begin
            beat0_load = 1'b1;
            vlan_vld_d = 1'b1;
            pkt_vld_d  = 1'b1;
            if (s_axis_tlast) begin
              segs_vld_d = 1'b1;
              seg_single = 1'b1;
            end else begin
              state_d = ST_SND;
            end
          end else if (!s_axis_tlast) begin
            state_d = ST_DROP;
          end
        end
        ST_SND: begin
          pkt_vld_d  = 1'b1;
          segs_vld_d = 1'b1;
          seg_pair   = 1'b1;
          state_d    = s_axis_tlast ? ST_IDLE : ST_FLUSH;
        end
        ST_FLUSH: begin
          pkt_vld_d = 1'b1;
          if (s_axis_tlast) state_d = ST_IDLE;
        end
        ST_DROP: begin
          if (s_axis_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Stage p0: beat0 capture, held until the segment is emitted
  always_ff @(posedge clk) begin
    if (beat0_load) begin
      beat0_tdata_p0 <= s_axis_tdata;
      beat0_tuser_p0 <= s_axis_tuser;
      beat0_tkeep_p0 <= s_axis_tkeep;
    end
  end

  // Stage p1: registered outputs, cleared on reset including data buses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pkt_valid  <= 1'b0;
      vlan_valid <= 1'b0;
      segs_valid <= 1'b0;
      pkt_tdata  <= '0;
      pkt_tuser  <= '0;
      pkt_tkeep  <= '0;
      pkt_tlast  <= 1'b0;
      vlan       <= '0;
      segs_tdata <= '0;
      segs_tuser <= '0;
      segs_tkeep <= '0;
      segs_tlast <= '0;
    end else begin
      state_q    <= state_d;
      pkt_valid  <= pkt_vld_d;
      vlan_valid <= vlan_vld_d;
      segs_valid <= segs_vld_d;
      if (pkt_vld_d) begin
        pkt_tdata <= s_axis_tdata;
        pkt_tuser <= s_axis_tuser;
        pkt_tkeep <= s_axis_tkeep;
        pkt_tlast <= s_axis_tlast;
      end
      if (vlan_vld_d) begin
        vlan <= {s_axis_tdata[VLAN_LO_OFF +: 4], s_axis_tdata[VLAN_HI_OFF +: 8]};
      end
      if (seg_single) begin
        segs_tdata <= {{(SEG_W-C_AXIS_DATA_WIDTH){1'b0}}, s_axis_tdata};
        segs_tuser <= {{C_AXIS_TUSER_WIDTH{1'b0}}, s_axis_tuser};
        segs_tkeep <= {{KEEP_W{1'b0}}, s_axis_tkeep};
        segs_tlast <= 2'b01;
      end else if (seg_pair) begin
        segs_tdata <= {s_axis_tdata, beat0_tdata_p0};
        segs_tuser <= {s_axis_tuser, beat0_tuser_p0};
        segs_tkeep <= {s_axis_tkeep, beat0_tkeep_p0};
        segs_tlast <= {s_axis_tlast, 1'b0};
      end
    end
  end

endmodule

// File: doc/parser_wait_segs.md
# parser_wait_segs

Ingress-side segment collector that feeds the parser and packet buffer. It accepts the 256-bit AXI-Stream packet stream and captures the first two beats (64 B) as one header segment for the parser. It extracts the 12-bit VLAN ID from beat 0 and forwards every beat unchanged to the packet-buffer FIFO. It sits between the ingress AXIS port and the parser's segment, VLAN and packet `fallthrough_small_fifo` instances; the deparser performs the reverse recombination.

## Interface
- `C_AXIS_DATA_WIDTH`, 256, stream data width.
- `C_AXIS_TUSER_WIDTH`, 128, stream tuser width.
- `C_VLANID_WIDTH`, 12, VLAN ID width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  256  ingress data.
- `s_axis_tkeep`  in  32  ingress byte enables.
- `s_axis_tuser`  in  128  ingress metadata.
- `s_axis_tvalid`  in  1  ingress valid.
- `s_axis_tlast`  in  1  ingress last beat.
- `s_axis_tready`  out  1  ingress ready.
- `segs_tdata`  out  512  {beat1, beat0}, beat0 in low half.
- `segs_tuser`  out  256  {tuser1, tuser0}.
- `segs_tkeep`  out  64  {tkeep1, tkeep0}.
- `segs_tlast`  out  2  {tlast1, tlast0}.
- `segs_valid`  out  1  one-cycle write strobe to the segment FIFO.
- `segs_ready`  in  1  ~nearly_full of the segment FIFO.
- `vlan`  out  12  extracted VLAN ID.
- `vlan_valid`  out  1  one-cycle write strobe to the VLAN FIFO.
- `vlan_ready`  in  1  ~nearly_full of the VLAN FIFO.
- `pkt_tdata`  out  256  forwarded beat data.
- `pkt_tuser`  out  128  forwarded beat tuser.
- `pkt_tkeep`  out  32  forwarded beat tkeep.
- `pkt_tlast`  out  1  forwarded beat tlast.
- `pkt_valid`  out  1  write strobe to the packet FIFO.
- `pkt_ready`  in  1  ~nearly_full of the packet FIFO.

## Operation
- `s_axis_tready` is combinational: `pkt_ready & segs_ready & vlan_ready`. It is also 0 during reset.
- A beat is accepted when `tvalid & tready`. Only accepted beats advance the FSM.
- **IDLE** (packet start):
  - Accepted beat is latched as beat0.
  - `vlan` = {tdata[115:112], tdata[127:120]}. This is the TCI low 12 bits; byte 14 sits at bits 119:112 and byte 15 at bits 127:120.
  - `vlan_valid` pulses.
  - If tlast is set, the FSM emits the segment immediately with the upper half zeroed, tlast = 2'b01 and tkeep1 = 0, and stays in IDLE.
  - Otherwise the FSM goes to **SND**.
- **SND**:
  - Accepted beat is latched as beat1 and `segs_valid` pulses.
  - If tlast is set, segs_tlast = 2'b10 and the FSM goes to IDLE; otherwise it goes to **FLUSH**.
- **FLUSH**: beats are forwarded to the packet FIFO only. The accepted tlast returns the FSM to IDLE.
- Every accepted beat produces exactly one `pkt_valid` pulse carrying that beat's fields unchanged.
- Outputs are strobes with no hold. The downstream FIFOs' nearly_full margin absorbs the one-cycle pipeline.

## Timing
- All outputs are registered.
- `pkt_*` appear 1 cycle after acceptance.
- `vlan_valid` appears 1 cycle after the beat0 acceptance.
- `segs_valid` appears 1 cycle after the beat1 acceptance, or after a single-beat tlast.
- Idle cycles between accepted beats are permitted. The FSM holds its state and all strobes are 0.
- Back-to-back packets run at full rate, with a new packet's beat0 on the cycle after the previous tlast.
- Reset values are 0 for every output, including data buses, and the FSM is in IDLE.
- Reset mid-packet discards the partial segment and any remaining beats are treated as a new packet. Upstream is reset together with this block.

## Configuration
- `PARSER_VLAN_CHECK_EN`:
  - Defined: beat0 must carry TPID 0x8100, i.e. tdata[103:96]=8'h81 and tdata[111:104]=8'h00. A non-matching packet is still accepted at full rate, but `pkt_valid`, `segs_valid` and `vlan_valid` stay 0 until its tlast. An internal DROP state is entered from IDLE and exits on tlast; a single-beat mismatch stays in IDLE.
  - Undefined: every packet is forwarded and tagging is not inspected.

## Structure
- Shared package `rmt_pkg` holds:
  - the state encoding (IDLE, SND, FLUSH, DROP);
  - VLAN bit offsets 112 and 120;
  - TPID byte offsets 96 and 104, and the value 16'h8100;
  - the segment width 2*C_AXIS_DATA_WIDTH.
- No sub-module: a single FSM plus output registers.

## Test plan
- 4-beat tagged packet with VID 0x123 and all ready high:
  - beat0 → vlan 0x123, vlan_valid at +1;
  - beat1 → segs_valid at +1 with segs_tlast 2'b00;
  - 4 pkt_valid pulses, the last with tlast.
- 1-beat packet, tkeep 32'h0000_FFFF → segs_tdata[511:256]=0, segs_tkeep=64'h0000_0000_0000_FFFF, segs_tlast 2'b01, one pkt beat.
- 2-beat packet → segs_tlast 2'b10; the next packet's beat0 on the following cycle is treated as beat0 (new vlan_valid).
- `segs_ready` low for 5 cycles mid-stream → tready 0, no accepted beats, no strobes; the resumed stream matches the input exactly.
- With `PARSER_VLAN_CHECK_EN`, an untagged 3-beat packet (TPID 0x0800) → no strobes for 3 cycles; the following tagged packet is forwarded normally.
- Reset asserted during FLUSH → all outputs 0 next cycle; the next beat is processed as beat0.
